// File: rtl/intc_pri_scan.sv
// intc_pri_scan: sequential interrupt priority resolver, one source per cycle.
// INTC_SCAN_PREEMPT_EN adds a background rescan while presenting.
module intc_pri_scan #(
   parameter int N_SRC  = 8,
   parameter int PRI_DW = 4,
   parameter int DW     = PRI_DW + 8,
   parameter int IDW    = $clog2(N_SRC)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_SRC-1:0]    req_i,
   input  logic [N_SRC*DW-1:0] dat_i,
   input  logic [PRI_DW-1:0]   lvl_i,
   input  logic                ack_i,
   output logic                irq_o,
   output logic [DW-1:0]       irq_dat_o,
   output logic [IDW-1:0]      irq_id_o,
   output logic [N_SRC-1:0]    ack_src_o
);

   typedef enum logic [1:0] {
      SCAN,
      PRESENT,
      ACK
   } state_e;

   state_e            state_q;
   logic [IDW-1:0]    idx_q;
   logic              best_v_q;
   logic [DW-1:0]     best_dat_q;
   logic [IDW-1:0]    best_id_q;
   logic              irq_q;
   logic [DW-1:0]     irq_dat_q;
   logic [IDW-1:0]    irq_id_q;
   logic [N_SRC-1:0]  ack_src_q;

   logic [DW-1:0]     cand_dat;
   logic [PRI_DW-1:0] cand_pri;
   logic              cand_ok;
   logic              take;
   logic              last;
   logic              scanning;
   logic              win_v_d;
   logic [DW-1:0]     win_dat_d;
   logic [IDW-1:0]    win_id_d;
   logic [N_SRC-1:0]  onehot;

   assign cand_dat = dat_i[32'(idx_q)*DW +: DW];
   assign cand_pri = cand_dat[8 +: PRI_DW];
   assign cand_ok  = req_i[idx_q] && (cand_pri != '0)
                     && (cand_pri > lvl_i);
   // strict compare keeps the lower index on a tie
   assign take     = cand_ok && (!best_v_q
                     || (cand_pri > best_dat_q[8 +: PRI_DW]));
   assign last     = (idx_q == IDW'(N_SRC - 1));

   assign win_v_d   = best_v_q || cand_ok;
   assign win_dat_d = take ? cand_dat : best_dat_q;
   assign win_id_d  = take ? idx_q : best_id_q;

   assign onehot = {{(N_SRC-1){1'b0}}, 1'b1} << irq_id_q;

`ifdef INTC_SCAN_PREEMPT_EN
   assign scanning = (state_q == SCAN)
                     || ((state_q == PRESENT) && !ack_i);
`else
   assign scanning = (state_q == SCAN);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= SCAN;
         idx_q      <= '0;
         best_v_q   <= 1'b0;
         best_dat_q <= '0;
         best_id_q  <= '0;
         irq_q      <= 1'b0;
         irq_dat_q  <= '0;
         irq_id_q   <= '0;
         ack_src_q  <= '0;
      end else begin
         if (scanning) begin
            if (last) begin
               idx_q    <= '0;
               best_v_q <= 1'b0;
            end else begin
               idx_q      <= idx_q + IDW'(1);
               best_v_q   <= win_v_d;
               best_dat_q <= win_dat_d;
               best_id_q  <= win_id_d;
            end
         end
         unique case (state_q)
            SCAN: begin
               if (last && win_v_d) begin
                  irq_q     <= 1'b1;
                  irq_dat_q <= win_dat_d;
                  irq_id_q  <= win_id_d;
                  state_q   <= PRESENT;
               end
            end
            PRESENT: begin
               if (ack_i) begin
                  irq_q     <= 1'b0;
                  ack_src_q <= onehot;
                  state_q   <= ACK;
               end
`ifdef INTC_SCAN_PREEMPT_EN
               else if (last) begin
                  if (!win_v_d) begin
                     irq_q   <= 1'b0;
                     state_q <= SCAN;
                  end else if (win_dat_d[8 +: PRI_DW]
                               > irq_dat_q[8 +: PRI_DW]) begin
                     irq_dat_q <= win_dat_d;
                     irq_id_q  <= win_id_d;
                  end
               end
`endif
            end
            ACK: begin
               ack_src_q <= '0;
               idx_q     <= '0;
               best_v_q  <= 1'b0;
               state_q   <= SCAN;
            end
            default: state_q <= SCAN;
         endcase
      end
   end

   assign irq_o     = irq_q;
   assign irq_dat_o = irq_dat_q;
   assign irq_id_o  = irq_id_q;
   assign ack_src_o = ack_src_q;

endmodule

// File: tb/tb_intc_pri_scan.sv
// tb_intc_pri_scan: directed vectors plus a pass-level model of intc_pri_scan.
// Define INTC_SCAN_PREEMPT_EN to cover preemption and withdrawal.
`timescale 1ns/1ps
module tb_intc_pri_scan;
   localparam int N   = 8;
   localparam int PW  = 4;
   localparam int DW  = 12;
   localparam int IDW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req = '0;
   logic [N*DW-1:0] dat = '0;
   logic [PW-1:0] lvl = '0;
   logic          ack = 1'b0;
   logic          irq_o;
   logic [DW-1:0] irq_dat_o;
   logic [IDW-1:0] irq_id_o;
   logic [N-1:0]  ack_src_o;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   intc_pri_scan #(.N_SRC(N), .PRI_DW(PW)) dut (
      .clk(clk), .rst(rst), .req_i(req), .dat_i(dat),
      .lvl_i(lvl), .ack_i(ack), .irq_o(irq_o),
      .irq_dat_o(irq_dat_o), .irq_id_o(irq_id_o),
      .ack_src_o(ack_src_o)
   );

   always #5 clk = ~clk;

   // model: collect one sample per scan position, pick the winner per pass
   bit             m_hold, m_clr;
   int             m_pos;
   logic           m_irq;
   logic [DW-1:0]  m_dat;
   logic [IDW-1:0] m_id;
   logic [N-1:0]   m_pulse;
   bit             s_ok [N];
   logic [DW-1:0]  s_dat [N];

   task automatic model_step();
      logic [DW-1:0] w;
      int best;
      bit scan;
      if (rst) begin
         m_hold = 0; m_clr = 0; m_pos = 0;
         m_irq = 0; m_dat = '0; m_id = '0; m_pulse = '0;
         return;
      end
      if (m_clr) begin
         m_clr = 0; m_pulse = '0; m_pos = 0;
         return;
      end
      if (m_hold && ack) begin
         m_hold = 0; m_clr = 1; m_irq = 0;
         m_pulse = N'(1) << m_id;
         return;
      end
`ifdef INTC_SCAN_PREEMPT_EN
      scan = 1;
`else
      scan = !m_hold;
`endif
      if (!scan) return;
      w = dat[m_pos*DW +: DW];
      s_dat[m_pos] = w;
      s_ok[m_pos] = req[m_pos] && (w[11:8] != 0) && (w[11:8] > lvl);
      m_pos++;
      if (m_pos < N) return;
      m_pos = 0;
      best = -1;
      for (int k = 0; k < N; k++)
         if (s_ok[k] && (best < 0 || s_dat[k][11:8] > s_dat[best][11:8]))
            best = k;
      if (!m_hold) begin
         if (best >= 0) begin
            m_hold = 1; m_irq = 1;
            m_dat = s_dat[best]; m_id = IDW'(best);
         end
      end else if (best < 0) begin
         m_hold = 0; m_irq = 0;
      end else if (s_dat[best][11:8] > m_dat[11:8]) begin
         m_dat = s_dat[best]; m_id = IDW'(best);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      wait (chk_en);
      forever begin
         @(posedge clk); #1;
         cmp("model irq_o", irq_o, m_irq);
         cmp("model irq_dat_o", irq_dat_o, m_dat);
         cmp("model irq_id_o", irq_id_o, m_id);
         cmp("model ack_src_o", ack_src_o, m_pulse);
      end
   end

   task automatic wait_irq(input int lim, output int n);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!irq_o && n < lim);
      checks++;
      if (!irq_o) begin
         errors++;
         $display("FAIL irq timeout: irq_o=0 after %0d cycles, expected 1", n);
      end
   endtask

   task automatic do_ack(logic [N-1:0] pulse, int k);
      @(negedge clk); ack = 1'b1;
      @(posedge clk); #1;
      cmp("ack irq low", irq_o, 0);
      cmp("ack pulse", ack_src_o, pulse);
      @(negedge clk); ack = 1'b0;
      if (k >= 0) req[k] = 1'b0;
      @(posedge clk); #1;
      cmp("pulse width", ack_src_o, 0);
   endtask

   task automatic quiet(int cyc, output int seen);
      seen = 0;
      for (int i = 0; i < cyc; i++) begin
         @(posedge clk); #1;
         if (irq_o) seen++;
      end
   endtask

   task automatic chk_zero(string nm);
      cmp({nm, " irq"}, irq_o, 0);
      cmp({nm, " dat"}, irq_dat_o, 0);
      cmp({nm, " id"}, irq_id_o, 0);
      cmp({nm, " ack_src"}, ack_src_o, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int bad;
      req[5] = 1'b1;
      dat[5*DW +: DW] = 12'h325;
      @(posedge clk); #1;
      chk_en = 1'b1;
      chk_zero("reset");
      @(negedge clk); rst = 1'b0;

      // single source
      wait_irq(20, n);
      cmp("first latency", n, 8);
      cmp("first dat", irq_dat_o, 12'h325);
      cmp("first id", irq_id_o, 5);
      cmp("model pin id", m_id, 5);
      do_ack(8'h20, 5);

      // tie between sources 1 and 6
      @(negedge clk);
      req[1] = 1'b1; dat[1*DW +: DW] = 12'h7AA;
      req[6] = 1'b1; dat[6*DW +: DW] = 12'h711;
      wait_irq(20, n);
      cmp("tie id", irq_id_o, 1);
      cmp("tie dat", irq_dat_o, 12'h7AA);
      do_ack(8'h02, 1);
      wait_irq(20, n);
      cmp("tie second id", irq_id_o, 6);
      cmp("model pin dat", m_dat, 12'h711);
      do_ack(8'h40, 6);

      // mask level
      @(negedge clk);
      lvl = 4'd5;
      req[2] = 1'b1; dat[2*DW +: DW] = 12'h502;
      req[3] = 1'b1; dat[3*DW +: DW] = 12'h603;
      wait_irq(20, n);
      cmp("mask id", irq_id_o, 3);
      do_ack(8'h08, 3);
      @(negedge clk);
      lvl = 4'd7;
      req[4] = 1'b1; dat[4*DW +: DW] = 12'h704;
      quiet(24, bad);
      cmp("masked no irq", bad, 0);
      @(negedge clk);
      req[2] = 1'b0; req[4] = 1'b0; lvl = 4'd0;
      req[0] = 1'b1; dat[0*DW +: DW] = 12'h0FF;
      quiet(24, bad);
      cmp("pri0 no irq", bad, 0);
      @(negedge clk); req[0] = 1'b0;

      // reset in PRESENT and mid-scan
      @(negedge clk);
      req[5] = 1'b1; dat[5*DW +: DW] = 12'h325;
      wait_irq(20, n);
      cmp("pre-reset id", irq_id_o, 5);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk_zero("rst present");
      @(negedge clk); rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk_zero("rst scan");
      @(negedge clk); rst = 1'b0;
      wait_irq(20, n);
      cmp("post-reset latency", n, 8);
      cmp("post-reset id", irq_id_o, 5);
      do_ack(8'h20, 5);

      // higher priority arrives while presenting
      @(negedge clk);
      req[0] = 1'b1; dat[0*DW +: DW] = 12'h2A0;
      wait_irq(20, n);
      cmp("low id", irq_id_o, 0);
      @(negedge clk);
      req[4] = 1'b1; dat[4*DW +: DW] = 12'h9B4;
`ifdef INTC_SCAN_PREEMPT_EN
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         if (!irq_o) bad++;
         if (irq_id_o == 3'd4) break;
      end
      cmp("preempt id", irq_id_o, 4);
      cmp("preempt dat", irq_dat_o, 12'h9B4);
      cmp("preempt irq held", bad, 0);
      do_ack(8'h10, 4);
      wait_irq(20, n);
      cmp("after preempt id", irq_id_o, 0);
      do_ack(8'h01, 0);

      // withdrawal
      @(negedge clk);
      req[3] = 1'b1; dat[3*DW +: DW] = 12'h533;
      wait_irq(20, n);
      cmp("withdraw id", irq_id_o, 3);
      @(negedge clk); req[3] = 1'b0;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (irq_o && n < 16);
      cmp("withdraw irq", irq_o, 0);
      @(negedge clk); ack = 1'b1;
      @(posedge clk); #1;
      cmp("withdraw no pulse", ack_src_o, 0);
      @(negedge clk); ack = 1'b0;
      @(posedge clk); #1;
      cmp("withdraw no pulse 2", ack_src_o, 0);
`else
      bad = 0;
      for (int i = 0; i < 24; i++) begin
         @(posedge clk); #1;
         if (!irq_o || irq_id_o != 3'd0) bad++;
      end
      cmp("frozen present", bad, 0);
      do_ack(8'h01, 0);
      wait_irq(20, n);
      cmp("next id", irq_id_o, 4);
      cmp("next dat", irq_dat_o, 12'h9B4);
      do_ack(8'h10, 4);
`endif

      repeat (3) @(posedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/intc_pri_scan.md
# intc_pri_scan

Sequential interrupt priority resolver for one CPU. It scans N_SRC interrupt sources one per cycle. For each source it applies the same priority-compare rule as the 2-to-1 selector: an `{priority, vector}` word, with the winner chosen by strict priority. It presents the winning request to the CPU, holds it until the CPU acknowledges, and then issues a one-hot clear pulse back to the winning source. It sits between the per-source request registers and the CPU interrupt inputs, so N-way selection needs no N-input comparator tree.

## Interface
Parameters:
- `N_SRC`, default 8: number of interrupt sources, ≥2.
- `PRI_DW`, default 4: priority field width.
- `DW`, default `PRI_DW+8`: request word width. Bits [DW-1:8] hold the priority; bits [7:0] hold the vector.
- `IDW`, default `$clog2(N_SRC)`: source index width.

Ports:
- `clk`  in  1: single clock. All flops are on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_i`  in  N_SRC: level request per source.
- `dat_i`  in  N_SRC*DW: request word of source k at `[k*DW +: DW]`.
- `lvl_i`  in  PRI_DW: CPU mask level. A request is eligible only if its priority is greater than `lvl_i`.
- `ack_i`  in  1: CPU accept. It is meaningful only while `irq_o`=1.
- `irq_o`  out  1: interrupt request to the CPU (registered).
- `irq_dat_o`  out  DW: presented request word (registered).
- `irq_id_o`  out  IDW: index of the presented source (registered).
- `ack_src_o`  out  N_SRC: one-cycle one-hot clear pulse to the accepted source (registered).

## Operation
FSM states: SCAN, PRESENT, ACK. Internal registers:
- `idx`: scan index, 0..N_SRC-1.
- `best_v`, `best_dat`, `best_id`: the running winner.

SCAN:
- Each cycle, evaluate candidate `idx`. It is eligible if `req_i[idx]`=1, its priority is ≠0, and its priority > `lvl_i`, all sampled that cycle.
- If eligible and `best_v`=0, the candidate is taken.
- If eligible and `best_v`=1, the candidate replaces the best only if its priority > the best priority (strict comparison). Ties therefore go to the lower index.
- On the cycle `idx`=N_SRC-1, the winner includes that candidate:
  - If a winner exists: load `irq_dat_o`/`irq_id_o`, set `irq_o`=1, clear `best_v`, set `idx`=0, go to PRESENT.
  - Otherwise: clear `best_v`, set `idx`=0, stay in SCAN.
- The vector field never affects the compare.

PRESENT:
- Outputs are frozen. `lvl_i` is not re-evaluated (see Configuration).
- When `ack_i`=1: `irq_o`←0, `ack_src_o`←onehot(`irq_id_o`), go to ACK.
- `irq_dat_o`/`irq_id_o` hold their last value after the ack.

ACK:
- Lasts exactly one cycle.
- `ack_src_o`←0, `idx`=0, go to SCAN.
- Sources must drop `req_i` on the cycle after the pulse, so the next scan never sees the accepted request.

Other rules:
- `ack_i` is ignored in SCAN and ACK.
- Reset, including mid-scan or mid-present: state SCAN, `idx`=0, `best_v`=0, and all outputs 0.

## Timing
- Scan pass: N_SRC cycles. `irq_o` rises on the edge that evaluates `idx`=N_SRC-1.
- Request valid from before the `idx`=0 cycle: `irq_o` is high N_SRC cycles after the pass starts.
- Worst-case latency from request to `irq_o`: 2·N_SRC cycles.
- `ack_i` high in PRESENT at edge t:
  - `irq_o`=0 and `ack_src_o` pulse during cycle t+1.
  - Rescan begins at t+2.
- A request dropped mid-scan after its index has been evaluated is still presented. There is no withdrawal in the base build.

## Configuration
Macro: `INTC_SCAN_PREEMPT_EN`.

Defined:
- In PRESENT, a background scan runs continuously with the same rules, including `lvl_i`.
- At the end of each pass:
  - No winner: `irq_o`←0, go to SCAN (withdrawal).
  - Winner priority > presented priority: `irq_dat_o`/`irq_id_o` are replaced and the block stays in PRESENT.
  - Otherwise: outputs are unchanged.
- If `ack_i` coincides with a replacement edge, the ack applies to the pre-edge `irq_id_o` and the ack takes precedence over the replacement.

Undefined:
- PRESENT is frozen until `ack_i`, with no background scan logic.

## Test plan
- N_SRC=8, only source 5 requesting with dat=0x325, `lvl_i`=0, request set before the pass starts:
  - `irq_o`=1 after 8 cycles with `irq_dat_o`=0x325 and `irq_id_o`=5.
  - `ack_i` pulse → `ack_src_o`=8'h20 for exactly one cycle and `irq_o`=0.
- Tie: sources 1 and 6 both at priority 7 → `irq_id_o`=1. After ack and source 1 dropping → next pass presents `irq_id_o`=6.
- Mask level:
  - `lvl_i`=5, source 2 at priority 5, source 3 at priority 6 → `irq_id_o`=3.
  - `lvl_i`=7 → `irq_o` stays 0 across three passes.
  - Priority-0 request → never presented.
- Reset: assert `rst` in PRESENT and in the middle of SCAN → next cycle all outputs are 0 and `idx`=0. The first pass after release presents the winner within 8 cycles.
- Preemption: present source 0 at priority 2, then raise source 4 at priority 9.
  - With `INTC_SCAN_PREEMPT_EN`: within 16 cycles `irq_id_o`=4 with priority 9 while `irq_o` stays 1.
  - Without the macro: output stays at source 0 until `ack_i`.
- Withdrawal (macro defined): drop the presented request → `irq_o`=0 within 16 cycles, and `ack_i` afterwards produces no `ack_src_o`.
